// File: rtl/dom_and_masked_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dom_and_masked_pipe
// Function : Domain-oriented masked AND with registered product stage and
//            valid/ready handshake qualified by fresh-randomness valid.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dom_and_masked_pipe #(
  parameter int  WIDTH  = 1,
  parameter int  SHARES = 2,
  localparam int RND_W  = WIDTH * SHARES * (SHARES - 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHARES*WIDTH-1:0]   a_sh,
  input  logic [SHARES*WIDTH-1:0]   b_sh,
  input  logic [RND_W-1:0]          rnd,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SHARES*WIDTH-1:0]   c_sh
);

  localparam int c_num_p = SHARES * SHARES;

  logic [c_num_p*WIDTH-1:0] w_p;
  logic [c_num_p*WIDTH-1:0] r_p;
  logic                     r_out_valid;
  logic                     w_accept;
  logic [SHARES*WIDTH-1:0]  w_c;

  assign in_ready  = rnd_valid & (~r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign rnd_ready = w_accept;
  assign out_valid = r_out_valid;

  // P[i][j] lives at slot i*SHARES+j; mirrored cross terms share one mask z_k
  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      if (gi == gj) begin : g_inner
        assign w_p[(gi*SHARES+gj)*WIDTH +: WIDTH] =
          a_sh[gi*WIDTH +: WIDTH] & b_sh[gi*WIDTH +: WIDTH];
      end else begin : g_cross
        localparam int c_lo = (gi < gj) ? gi : gj;
        localparam int c_hi = (gi < gj) ? gj : gi;
        localparam int c_k  = c_lo*SHARES - c_lo*(c_lo+1)/2 + (c_hi - c_lo - 1);
        assign w_p[(gi*SHARES+gj)*WIDTH +: WIDTH] =
          (a_sh[gi*WIDTH +: WIDTH] & b_sh[gj*WIDTH +: WIDTH]) ^ rnd[c_k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_p         <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_p         <= w_p;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Integration reads registered products only, so no glitch path from inputs
  always_comb begin
    w_c = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int j = 0; j < SHARES; j++) begin
        w_c[s*WIDTH +: WIDTH] = w_c[s*WIDTH +: WIDTH] ^ r_p[(s*SHARES+j)*WIDTH +: WIDTH];
      end
    end
  end

  assign c_sh = w_c;

endmodule
`default_nettype wire

// File: tb/tb_dom_and_masked_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_dom_and_masked_pipe
// Function : Scoreboard bench for the masked AND pipe (2-share/1-bit exact
//            shares, 3-share/8-bit unmasked result).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_dom_and_masked_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  // 2 shares, 1-bit lanes
  logic       in_valid2, in_ready2, rnd_valid2, rnd_ready2, out_valid2, out_ready2;
  logic [1:0] a2, b2, c2;
  logic [0:0] rnd2;
  // 3 shares, 8-bit lanes
  logic        in_valid3, in_ready3, rnd_valid3, rnd_ready3, out_valid3, out_ready3;
  logic [23:0] a3, b3, c3, rnd3;

  logic [1:0] q2[$];
  logic [7:0] q3[$];
  int nacc2 = 0, nrnd2 = 0, nacc3 = 0, nrnd3 = 0;

  dom_and_masked_pipe #(.WIDTH(1), .SHARES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_sh(a2), .b_sh(b2), .rnd(rnd2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .c_sh(c2)
  );

  dom_and_masked_pipe #(.WIDTH(8), .SHARES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_sh(a3), .b_sh(b3), .rnd(rnd3), .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3),
    .out_valid(out_valid3), .out_ready(out_ready3), .c_sh(c3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] unmask3(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  // Monitor: pops one expected result per transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (rnd_ready2) nrnd2++;
      if (rnd_ready3) nrnd3++;
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) chk("c2_unexpected_output", 1, 0);
        else chk("c2_shares", c2, q2.pop_front());
      end
      if (out_valid3 && out_ready3) begin
        if (q3.size() == 0) chk("c3_unexpected_output", 1, 0);
        else chk("c3_unmasked", unmask3(c3), q3.pop_front());
      end
    end
  end

  task automatic send2(input logic [1:0] a, input logic [1:0] b, input logic z,
                       input logic [1:0] cexp, input string nm);
    int n = 0;
    a2 = a; b2 = b; rnd2 = z; in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (in_ready2) begin
      q2.push_back(cexp);
      nacc2++;
    end
    chk({nm, "_accept_wait"}, n, 0);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk({nm, "_latency"}, out_valid2, 1);
  endtask

  task automatic send3(input logic [23:0] a, input logic [23:0] b);
    bit acc = 1'b0;
    a3 = a; b3 = b; in_valid3 = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      rnd3       = 24'($urandom);
      rnd_valid3 = ($urandom_range(0, 3) != 0);
      out_ready3 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_ready3) begin
        acc = 1'b1;
        q3.push_back(unmask3(a) & unmask3(b));
        nacc3++;
      end
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    chk("u3_accept_timeout", acc, 1);
    chk("u3_latency", out_valid3, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid2 = 0; a2 = 0; b2 = 0; rnd2 = 0; rnd_valid2 = 1; out_ready2 = 1;
    in_valid3 = 0; a3 = 0; b3 = 0; rnd3 = 0; rnd_valid3 = 1; out_ready3 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid2, 0);
    chk("reset_c_sh", c2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready2, 1);
    chk("idle_rnd_ready", rnd_ready2, 0);
    @(posedge clk); #1;

    // basic vector: a=01, b=11, z=1 -> c=11
    send2(2'b01, 2'b11, 1'b1, 2'b11, "t1");
    @(posedge clk); #1;
    chk("t1_out_valid_clears", out_valid2, 0);

    // backpressure: result held for 5 cycles while a new op waits
    out_ready2 = 1'b0;
    send2(2'b11, 2'b01, 1'b0, 2'b11, "t3_op");
    a2 = 2'b10; b2 = 2'b01; rnd2 = 1'b1; in_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_c_sh", c2, 2'b11);
      chk("t3_stall_in_ready", in_ready2, 0);
      chk("t3_stall_rnd_ready", rnd_ready2, 0);
      chk("t3_stall_out_valid", out_valid2, 1);
    end
    @(posedge clk); #1;
    out_ready2 = 1'b1;
    send2(2'b10, 2'b01, 1'b1, 2'b01, "t3_drain_accept");

    // no fresh randomness: nothing accepted, pending output still drains
    rnd_valid2 = 1'b0;
    a2 = 2'b01; b2 = 2'b10; rnd2 = 1'b0; in_valid2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready2, 0);
      chk("t4_rnd_ready", rnd_ready2, 0);
      chk("t4_out_valid", out_valid2, (i == 0));
    end
    @(posedge clk); #1;
    rnd_valid2 = 1'b1;
    send2(2'b01, 2'b10, 1'b0, 2'b01, "t4_op");

    // back-to-back, one result per cycle
    send2(2'b11, 2'b11, 1'b1, 2'b11, "t5_op0");
    send2(2'b00, 2'b11, 1'b0, 2'b00, "t5_op1");
    send2(2'b10, 2'b10, 1'b0, 2'b10, "t5_op2");
    send2(2'b01, 2'b01, 1'b1, 2'b10, "t5_op3");
    @(posedge clk); #1;
    chk("t5_out_valid_clears", out_valid2, 0);

    // reset while a result is pending
    out_ready2 = 1'b0;
    send2(2'b11, 2'b01, 1'b0, 2'b11, "t6_pending");
    rst = 1'b1;
    q2.delete();
    @(posedge clk); #1;
    chk("t6_reset_out_valid", out_valid2, 0);
    chk("t6_reset_c_sh", c2, 0);
    rst = 1'b0;
    out_ready2 = 1'b1;
    send2(2'b01, 2'b11, 1'b1, 2'b11, "t6_after");
    @(posedge clk); #1;

    // 3 shares x 8 bits with random gaps in randomness and backpressure
    send3({8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'hFF});
    send3({8'hA5, 8'h5A, 8'h0F}, {8'h3C, 8'hC3, 8'hF0});
    send3({8'h12, 8'h34, 8'h56}, {8'h00, 8'h00, 8'h00});
    for (int i = 0; i < 60; i++) send3(24'($urandom), 24'($urandom));
    out_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("q2_drained", q2.size(), 0);
    chk("q3_drained", q3.size(), 0);
    chk("rnd2_count", nrnd2, nacc2);
    chk("rnd3_count", nrnd3, nacc3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
